fp_div_arbiter: RTL

Shares one pipelined single-precision divider (`FPDiv`, fixed latency, no stall input) between `NUM_REQ` requesters. Each cycle it grants at most one valid request by round-robin and launches the operands into the divider. It carries requester index and user tag down a shadow pipeline matching the divider latency, then returns each quotient to the requester that issued it. It sits between the SIMT/core lanes and the single divider instance.

---
 rtl/fp_div_arbiter_if.sv | 30 +++
 rtl/fp_div_arbiter.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/fp_div_arbiter_if.sv
// Requester-side bus of the shared divider arbiter.
//   req_valid/req_ready : per-requester handshake, one bit per requester
//   req_a/req_b         : packed binary32 operands, requester i at [32i +: 32]
//   req_tag             : packed opaque tags, requester i at [TAG_W*i +: TAG_W]
//   resp_valid          : one-hot (or zero) response strobe
//   resp_q/resp_tag     : shared quotient and echoed tag
// master = requester side, slave = arbiter side.
interface fp_div_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TAG_W   = 8
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [32*NUM_REQ-1:0]    req_a;
  logic [32*NUM_REQ-1:0]    req_b;
  logic [TAG_W*NUM_REQ-1:0] req_tag;
  logic [NUM_REQ-1:0]       resp_valid;
  logic [31:0]              resp_q;
  logic [TAG_W-1:0]         resp_tag;

  modport master (
    output req_valid, req_a, req_b, req_tag,
    input  req_ready, resp_valid, resp_q, resp_tag
  );

  modport slave (
    input  req_valid, req_a, req_b, req_tag,
    output req_ready, resp_valid, resp_q, resp_tag
  );
endinterface

// File: rtl/fp_div_arbiter.sv
// Round-robin arbiter sharing one fixed-latency pipelined FP divider between NUM_REQ requesters.
// A shadow pipeline carries {valid, index, tag} alongside the divider so each quotient returns
// to the requester that issued it.
//   clk     : clock, all state on rising edge
//   areset  : synchronous active-high reset; also forces all outputs to their idle values
//   bus     : requester handshake/operands and response strobe (slave side)
//   div_a/b : registered operands to the divider (zero when nothing launched)
//   div_q   : quotient from the divider, LATENCY cycles after div_a/div_b
//   busy    : at least one operation in flight
module fp_div_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned LATENCY = 10,
  parameter int unsigned TAG_W   = 8
) (
  input  logic                 clk,
  input  logic                 areset,
  fp_div_arbiter_if.slave      bus,
  output logic [31:0]          div_a,
  output logic [31:0]          div_b,
  input  logic [31:0]          div_q,
  output logic                 busy
);

  localparam int unsigned SelW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  // Index is kept at least 2 bits wide so the shadow format is the same for every NUM_REQ.
  localparam int unsigned IdxW = (SelW < 2) ? 2 : SelW;

  logic [IdxW-1:0]              r_ptr;
  logic [IdxW-1:0]              w_ptr_nxt;

  logic                         w_found;
  logic [IdxW-1:0]              w_gnt;
  logic [NUM_REQ-1:0]           w_ready;
  logic [31:0]                  w_a;
  logic [31:0]                  w_b;
  logic [TAG_W-1:0]             w_tag;

  logic                         r_lvld;
  logic [IdxW-1:0]              r_lidx;
  logic [TAG_W-1:0]             r_ltag;
  logic [31:0]                  r_div_a;
  logic [31:0]                  r_div_b;

  logic [LATENCY-1:0]             r_svld;
  logic [LATENCY-1:0][IdxW-1:0]   r_sidx;
  logic [LATENCY-1:0][TAG_W-1:0]  r_stag;

  logic                         w_last;

  // Round-robin pick: first scan indices at or above ptr, then wrap to those below it.
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    if (!areset) begin
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        if (!w_found && bus.req_valid[i] && (IdxW'(i) >= r_ptr)) begin
          w_found = 1'b1;
          w_gnt   = IdxW'(i);
        end
      end
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        if (!w_found && bus.req_valid[i] && (IdxW'(i) < r_ptr)) begin
          w_found = 1'b1;
          w_gnt   = IdxW'(i);
        end
      end
    end
  end

  // One-hot grant and operand mux; operands stay zero when nothing is granted.
  always_comb begin
    w_ready = '0;
    w_a     = '0;
    w_b     = '0;
    w_tag   = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (w_found && (w_gnt == IdxW'(i))) begin
        w_ready[i] = 1'b1;
        w_a        = bus.req_a[32*i +: 32];
        w_b        = bus.req_b[32*i +: 32];
        w_tag      = bus.req_tag[TAG_W*i +: TAG_W];
      end
    end
  end

  always_comb begin
    w_ptr_nxt = r_ptr;
    if (w_found) begin
      w_ptr_nxt = (w_gnt == IdxW'(NUM_REQ - 1)) ? '0 : w_gnt + 1'b1;
    end
  end

  // Launch stage
  always_ff @(posedge clk) begin
    if (areset) begin
      r_ptr   <= '0;
      r_lvld  <= 1'b0;
      r_lidx  <= '0;
      r_ltag  <= '0;
      r_div_a <= '0;
      r_div_b <= '0;
    end else begin
      r_ptr   <= w_ptr_nxt;
      r_lvld  <= w_found;
      r_lidx  <= w_gnt;
      r_ltag  <= w_tag;
      r_div_a <= w_a;
      r_div_b <= w_b;
    end
  end

  // Shadow pipeline: advances every cycle, in lockstep with the divider.
  always_ff @(posedge clk) begin
    if (areset) begin
      r_svld <= '0;
      r_sidx <= '0;
      r_stag <= '0;
    end else begin
      r_svld[0] <= r_lvld;
      r_sidx[0] <= r_lidx;
      r_stag[0] <= r_ltag;
      for (int i = 1; i < int'(LATENCY); i++) begin
        r_svld[i] <= r_svld[i-1];
        r_sidx[i] <= r_sidx[i-1];
        r_stag[i] <= r_stag[i-1];
      end
    end
  end

  // Outputs are gated by areset so the reset cycle itself is already idle.
  assign w_last = r_svld[LATENCY-1] && !areset;

  always_comb begin
    bus.resp_valid = '0;
    bus.resp_q     = '0;
    bus.resp_tag   = '0;
    if (w_last) begin
      bus.resp_q   = div_q;
      bus.resp_tag = r_stag[LATENCY-1];
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        bus.resp_valid[i] = (r_sidx[LATENCY-1] == IdxW'(i));
      end
    end
  end

  assign bus.req_ready = w_ready;
  assign div_a         = areset ? '0 : r_div_a;
  assign div_b         = areset ? '0 : r_div_b;
  assign busy          = !areset && (r_lvld || (|r_svld));

endmodule
